mul_seq_ctrl: RTL

- Iterative shift-add multiplier with its sequencing controller. It serves the MUL (unsigned) and SMUL (signed) ALU operations of the multi-cycle core.
- The main FSM pulses start, holds in its execute state while busy=1, then captures product and flags on done.
- It replaces a single-cycle combinational multiplier on the ALU result path and trades latency for area.

---
 rtl/mul_seq_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl -- iterative shift-add multiplier with its sequencing FSM.
// Serves the MUL (unsigned) and SMUL (signed) ALU operations. It trades a
// single-cycle array multiplier for WIDTH+2 cycles of fixed latency.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   start      request a multiply (sampled only in IDLE)
//   signed_op  1 = SMUL (two's complement), 0 = MUL (unsigned)
//   flush      synchronous abort back to IDLE, product left untouched
//   a, b       multiplicand / multiplier, latched on an accepted start
//   busy       high in RUN and FIX
//   done       one-cycle pulse in DONE; product and flags valid
//   product    full 2*WIDTH product, held until the next result
//   n_flag     product[WIDTH-1]
//   z_flag     product[WIDTH-1:0] == 0
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; operands latched on acceptance
// RUN   | one shift-add step per cycle, exactly WIDTH cycles
// FIX   | apply result sign, write product
// DONE  | done pulse, back to IDLE
module mul_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic                 flush,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 n_flag,
    output logic                 z_flag
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    // Upper half accumulates partial sums, lower half holds the multiplier
    // bits still to be consumed; both shift right together every step.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       step_sum;

    // The negation of the most-negative value wraps to itself, which read
    // as unsigned is exactly 2^(WIDTH-1), so no special case is needed.
    assign mag_a = (signed_op && a[WIDTH-1]) ? -a : a;
    assign mag_b = (signed_op && b[WIDTH-1]) ? -b : b;

    assign step_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        product_d = product_q;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = mag_a;
                    acc_d   = {{WIDTH{1'b0}}, mag_b};
                    neg_d   = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                acc_d = {step_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                busy      = 1'b1;
                product_d = neg_q ? -acc_q : acc_q;
                state_d   = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything, including a start in the same cycle
        // and the done pulse; the last good product is kept.
        if (flush) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            product_d = product_q;
            done      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;
    assign n_flag  = product_q[WIDTH-1];
    assign z_flag  = (product_q[WIDTH-1:0] == '0);

endmodule
